// File: rtl/shift_reg_unit.sv
// Shift register holding a datapath word; shifts one bit per clock with a busy/done handshake.
// Defining SHIFTREG_BARREL_EN replaces the iterative engine with a single-cycle barrel shifter.
module shift_reg_unit #(
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [2:0]               func,
  input  logic [$clog2(WIDTH)-1:0] n,
  input  logic [WIDTH-1:0]         data_in,
  output logic [WIDTH-1:0]         data_out,
  output logic                     busy,
  output logic                     done
);

  localparam int NW = $clog2(WIDTH);

  localparam logic [2:0] FN_LOAD = 3'b001;
  localparam logic [2:0] FN_SLL  = 3'b010;
  localparam logic [2:0] FN_SRL  = 3'b011;
  localparam logic [2:0] FN_SRA  = 3'b100;
  localparam logic [2:0] FN_ROR  = 3'b101;
  localparam logic [2:0] FN_ROL  = 3'b110;

  function automatic logic is_shift(input logic [2:0] f);
    return (f >= FN_SLL) && (f <= FN_ROL);
  endfunction

  logic [WIDTH-1:0] data_reg, data_next;
  logic             done_reg, done_next;

`ifdef SHIFTREG_BARREL_EN

  // Rotates come from a doubled word so the wrapped bits fall out of a plain shift.
  function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] x,
                                              input logic [2:0]       op,
                                              input logic [NW-1:0]    amt);
    logic [2*WIDTH-1:0] dbl_r;
    logic [2*WIDTH-1:0] dbl_l;
    dbl_r = {x, x} >> amt;
    dbl_l = {x, x} << amt;
    case (op)
      FN_SLL:  return x << amt;
      FN_SRL:  return x >> amt;
      FN_SRA:  return $unsigned($signed(x) >>> amt);
      FN_ROR:  return dbl_r[WIDTH-1:0];
      FN_ROL:  return dbl_l[2*WIDTH-1:WIDTH];
      default: return x;
    endcase
  endfunction

  always_comb begin
    data_next = data_reg;
    done_next = 1'b0;
    if (func == FN_LOAD) begin
      data_next = data_in;
      done_next = 1'b1;
    end else if (is_shift(func)) begin
      data_next = barrel(data_reg, func, n);
      done_next = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_reg <= '0;
      done_reg <= 1'b0;
    end else begin
      data_reg <= data_next;
      done_reg <= done_next;
    end
  end

  assign busy = 1'b0;

`else

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_reg, state_next;
  logic [NW-1:0]   cnt_reg, cnt_next;
  logic [2:0]      op_reg, op_next;

  function automatic logic [WIDTH-1:0] step1(input logic [WIDTH-1:0] x,
                                             input logic [2:0]       op);
    case (op)
      FN_SLL:  return {x[WIDTH-2:0], 1'b0};
      FN_SRL:  return {1'b0, x[WIDTH-1:1]};
      FN_SRA:  return {x[WIDTH-1], x[WIDTH-1:1]};
      FN_ROR:  return {x[0], x[WIDTH-1:1]};
      FN_ROL:  return {x[WIDTH-2:0], x[WIDTH-1]};
      default: return x;
    endcase
  endfunction

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    data_next  = data_reg;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (func == FN_LOAD) begin
          data_next = data_in;
          done_next = 1'b1;
        end else if (is_shift(func)) begin
          if (n == '0) begin
            done_next = 1'b1;
          end else begin
            op_next    = func;
            cnt_next   = n;
            state_next = SHIFT;
          end
        end
      end
      SHIFT: begin
        // Commands presented here are dropped; only the latched op advances.
        data_next = step1(data_reg, op_reg);
        cnt_next  = cnt_reg - NW'(1);
        if (cnt_reg == NW'(1)) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= 3'b000;
      data_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      data_reg  <= data_next;
      done_reg  <= done_next;
    end
  end

  assign busy = (state_reg == SHIFT);

`endif

  assign data_out = data_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_shift_reg_unit.sv
// Bench for shift_reg_unit: reset, directed table, NOP/ignore/mid-shift-reset sequences,
// and randomized commands checked against an arithmetic reference model.
module tb_shift_reg_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  func = 3'b000;
  logic [4:0]  n = 5'd0;
  logic [31:0] data_in = 32'h0;
  logic [31:0] data_out;
  logic        busy;
  logic        done;

`ifdef SHIFTREG_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] model_data = 32'h0;

  typedef struct {
    logic [2:0]  f;
    logic [4:0]  nn;
    logic [31:0] din;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[11];

  shift_reg_unit #(.WIDTH(32)) dut (
    .clk      (clk),
    .reset    (reset),
    .func     (func),
    .n        (n),
    .data_in  (data_in),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic on the specified function codes.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [2:0] f,
                                            input logic [4:0] nn, input logic [31:0] din);
    logic [63:0] dd;
    int          sh;
    case (f)
      3'b001: return din;
      3'b010: return d << nn;
      3'b011: return d >> nn;
      3'b100: return $unsigned($signed(d) >>> nn);
      3'b101: begin
        dd = {d, d} >> nn;
        return dd[31:0];
      end
      3'b110: begin
        sh = (32 - int'(nn)) % 32;
        dd = {d, d} >> sh;
        return dd[31:0];
      end
      default: return d;
    endcase
  endfunction

  // Called at a negedge; returns at a negedge one cycle after done.
  task automatic run_cmd(input logic [2:0] f, input logic [4:0] nn, input logic [31:0] din,
                         input logic [31:0] exp, input bit noise);
    int exp_k;
    exp_k = (f == 3'b001 || nn == 5'd0 || BARREL) ? 1 : int'(nn) + 1;
    func = f;
    n = nn;
    data_in = din;
    @(posedge clk);
    #1;
    if (noise && exp_k > 1) begin
      func = 3'b001;
      data_in = 32'h0;
    end else begin
      func = 3'b000;
    end
    for (int k = 1; k <= exp_k; k++) begin
      @(negedge clk);
      chk("busy", 32'(busy), 32'(k < exp_k));
      chk("done", 32'(done), 32'(k == exp_k));
      if (k == exp_k - 1) func = 3'b000;
    end
    chk("data_out", data_out, exp);
    @(negedge clk);
    chk("done_single", 32'(done), 32'h0);
    chk("data_hold", data_out, exp);
    model_data = exp;
    $display("cmd func=%0d n=%0d din=0x%08h noise=%0d -> data_out=0x%08h", f, nn, din, noise, data_out);
  endtask

  initial begin
    tbl[0]  = '{3'b001, 5'd0,  32'h000000F0, 32'h000000F0};
    tbl[1]  = '{3'b010, 5'd4,  32'h0,        32'h00000F00};
    tbl[2]  = '{3'b001, 5'd0,  32'h80000000, 32'h80000000};
    tbl[3]  = '{3'b100, 5'd31, 32'h0,        32'hFFFFFFFF};
    tbl[4]  = '{3'b001, 5'd0,  32'h80000000, 32'h80000000};
    tbl[5]  = '{3'b011, 5'd31, 32'h0,        32'h00000001};
    tbl[6]  = '{3'b001, 5'd0,  32'h12345678, 32'h12345678};
    tbl[7]  = '{3'b110, 5'd8,  32'h0,        32'h34567812};
    tbl[8]  = '{3'b101, 5'd4,  32'h0,        32'h23456781};
    tbl[9]  = '{3'b001, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF};
    tbl[10] = '{3'b011, 5'd0,  32'h0,        32'hDEADBEEF};

    // Reset held two cycles with a LOAD pending
    reset = 1'b1;
    func = 3'b001;
    data_in = 32'hFFFFFFFF;
    repeat (2) begin
      @(negedge clk);
      chk("reset_data", data_out, 32'h0);
      chk("reset_busy", 32'(busy), 32'h0);
      chk("reset_done", 32'(done), 32'h0);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    func = 3'b000;
    @(negedge clk);
    chk("post_reset_load", data_out, 32'hFFFFFFFF);
    chk("post_reset_done", 32'(done), 32'h1);
    @(negedge clk);
    chk("post_reset_done_end", 32'(done), 32'h0);
    model_data = 32'hFFFFFFFF;
    $display("reset sequence -> data_out=0x%08h", data_out);

    for (int i = 0; i < 11; i++)
      run_cmd(tbl[i].f, tbl[i].nn, tbl[i].din, tbl[i].exp, 1'b0);

    // Both NOP codes leave everything alone
    func = 3'b000;
    @(negedge clk);
    chk("nop0_done", 32'(done), 32'h0);
    chk("nop0_data", data_out, 32'hDEADBEEF);
    func = 3'b111;
    @(negedge clk);
    chk("nop7_done", 32'(done), 32'h0);
    chk("nop7_busy", 32'(busy), 32'h0);
    chk("nop7_data", data_out, 32'hDEADBEEF);
    func = 3'b000;
    $display("nop sequence -> data_out=0x%08h", data_out);

    // LOAD presented while busy must be dropped
    run_cmd(3'b001, 5'd0, 32'h00000001, 32'h00000001, 1'b0);
    run_cmd(3'b010, 5'd6, 32'h0, 32'h00000040, 1'b1);

    // Reset in the middle of an SLL by 10
    run_cmd(3'b001, 5'd0, 32'h0000FFFF, 32'h0000FFFF, 1'b0);
    func = 3'b010;
    n = 5'd10;
    @(posedge clk);
    #1;
    func = 3'b000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_data", data_out, 32'h0);
    chk("midreset_busy", 32'(busy), 32'h0);
    chk("midreset_done", 32'(done), 32'h0);
    reset = 1'b0;
    @(negedge clk);
    chk("midreset_no_done", 32'(done), 32'h0);
    chk("midreset_idle", 32'(busy), 32'h0);
    chk("midreset_data_hold", data_out, 32'h0);
    model_data = 32'h0;
    $display("mid-shift reset -> data_out=0x%08h", data_out);
    run_cmd(3'b001, 5'd0, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);

    // Randomized commands against the reference model
    for (int i = 0; i < 40; i++) begin
      logic [2:0]  rf;
      logic [4:0]  rn;
      logic [31:0] rd;
      rf = 3'($urandom_range(1, 6));
      rn = 5'($urandom_range(0, 31));
      rd = $urandom;
      run_cmd(rf, rn, rd, ref_shift(model_data, rf, rn, rd), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
